// File: rtl/immediate_reader_pkg.sv
// rtl/immediate_reader_pkg.sv - shared types, constants and helpers for the immediate reader
//
// Contents:
//   imm_state_e   state encoding of the immediate reader FSM
//   IMM_BYTES_8   byte count reported for an 8-bit immediate
//   IMM_BYTES_16  byte count reported for a 16-bit immediate
//   extend_byte   widens a byte to 16 bits, zero- or sign-extended
//                 (also used by the displacement reader)

package immediate_reader_pkg;

  typedef enum logic [2:0] {
    IMM_IDLE       = 3'd0,
    IMM_FETCH_LO   = 3'd1,
    IMM_CAPTURE_LO = 3'd2,
    IMM_FETCH_HI   = 3'd3,
    IMM_CAPTURE_HI = 3'd4,
    IMM_DONE       = 3'd5
  } imm_state_e;

  localparam logic [1:0] IMM_BYTES_8  = 2'd1;
  localparam logic [1:0] IMM_BYTES_16 = 2'd2;

  function automatic logic [15:0] extend_byte(input logic [7:0] b, input logic sext);
    return sext ? {{8{b[7]}}, b} : {8'h00, b};
  endfunction

endpackage

// File: rtl/immediate_reader.sv
// rtl/immediate_reader.sv - pulls 1 or 2 bytes from the prefetch FIFO and assembles a 16-bit immediate
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   start         one-cycle request; honoured only in IDLE
//   is_8bit       sampled with start: 1 = one byte, 0 = two bytes
//   sign_extend   sampled with start: sign-extend an 8-bit operand
//   flush         stream flush (branch); aborts any request
//   fifo_rd_en    FIFO read strobe (combinational)
//   fifo_rd_data  FIFO byte, valid the cycle after fifo_rd_en
//   fifo_empty    FIFO empty flag
//   busy          high in every state except IDLE
//   complete      one-cycle pulse, immediate valid
//   immediate     assembled little-endian value, held until next capture
//   bytes_read    bytes consumed by the finished request, qualified by complete
//   ip_inc        one pulse per accepted FIFO read

module immediate_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_8bit,
  input  logic        sign_extend,
  input  logic        flush,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic        busy,
  output logic        complete,
  output logic [15:0] immediate,
  output logic [1:0]  bytes_read,
  output logic        ip_inc
);

  import immediate_reader_pkg::*;

  imm_state_e  state_q, state_d;
  logic        is8_q, is8_d;
  logic        sext_q, sext_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] imm_q, imm_d;
  logic        rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IMM_IDLE;
      is8_q   <= 1'b0;
      sext_q  <= 1'b0;
      lo_q    <= 8'h00;
      imm_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      is8_q   <= is8_d;
      sext_q  <= sext_d;
      lo_q    <= lo_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is8_d   = is8_q;
    sext_d  = sext_q;
    lo_d    = lo_q;
    imm_d   = imm_q;
    rd_en   = 1'b0;

    // A flush overrides everything: no read, no capture, straight back to IDLE.
    if (flush) begin
      state_d = IMM_IDLE;
    end else begin
      unique case (state_q)
        IMM_IDLE: begin
          if (start) begin
            is8_d   = is_8bit;
            sext_d  = sign_extend;
            state_d = IMM_FETCH_LO;
          end
        end

        IMM_FETCH_LO: begin
          if (!fifo_empty) begin
            rd_en   = 1'b1;
            state_d = IMM_CAPTURE_LO;
          end
        end

        IMM_CAPTURE_LO: begin
          lo_d = fifo_rd_data;
          if (is8_q) begin
            // An 8-bit operand is complete here, so the held value can be
            // updated now and presented in DONE.
            imm_d   = extend_byte(fifo_rd_data, sext_q);
            state_d = IMM_DONE;
          end else if (!fifo_empty) begin
            // Overlap the high-byte read with the low-byte capture.
            rd_en   = 1'b1;
            state_d = IMM_CAPTURE_HI;
          end else begin
            state_d = IMM_FETCH_HI;
          end
        end

        IMM_FETCH_HI: begin
          if (!fifo_empty) begin
            rd_en   = 1'b1;
            state_d = IMM_CAPTURE_HI;
          end
        end

        IMM_CAPTURE_HI: begin
          imm_d   = {fifo_rd_data, lo_q};
          state_d = IMM_DONE;
        end

        IMM_DONE: begin
          state_d = IMM_IDLE;
        end

        default: begin
          state_d = IMM_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en;
  assign ip_inc     = rd_en;
  assign busy       = (state_q != IMM_IDLE);
  assign complete   = (state_q == IMM_DONE);
  assign bytes_read = (state_q == IMM_DONE) ? (is8_q ? IMM_BYTES_8 : IMM_BYTES_16) : 2'd0;
  assign immediate  = imm_q;

endmodule

// File: tb/tb_immediate_reader.sv
// tb/tb_immediate_reader.sv - scoreboard testbench for immediate_reader

module tb_immediate_reader;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  nb;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_8bit;
  logic        sign_extend;
  logic        flush;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        busy;
  logic        complete;
  logic [15:0] immediate;
  logic [1:0]  bytes_read;
  logic        ip_inc;

  int          vectors;
  int          miscompares;
  int          cyc;
  int          ip_count;
  int          fifo_cnt;
  logic        fifo_take;
  logic [7:0]  fifo_q[$];
  exp_t        exp_q[$];

  immediate_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_8bit      (is_8bit),
    .sign_extend  (sign_extend),
    .flush        (flush),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .busy         (busy),
    .complete     (complete),
    .immediate    (immediate),
    .bytes_read   (bytes_read),
    .ip_inc       (ip_inc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty = (fifo_cnt == 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_cnt = fifo_q.size();
  endtask

  task automatic issue(input logic is8, input logic sext, output int t);
    start       = 1'b1;
    is_8bit     = is8;
    sign_extend = sext;
    t           = cyc;
    tick();
    start       = 1'b0;
  endtask

  task automatic expect_done(input logic [15:0] imm, input logic [1:0] nb, input int c);
    exp_t e;
    e.imm = imm;
    e.nb  = nb;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // FIFO model: a read seen during a cycle delivers its byte from the next cycle on.
  initial begin
    fifo_rd_data = 8'h00;
    fifo_take    = 1'b0;
    forever begin
      @(negedge clk);
      fifo_take = fifo_rd_en && (fifo_cnt > 0);
      @(posedge clk);
      #1;
      if (fifo_take) begin
        fifo_rd_data = fifo_q.pop_front();
        fifo_cnt     = fifo_q.size();
      end
    end
  end

  // Monitor: compares every complete against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (fifo_empty) chk("rd_en_while_empty", {31'd0, fifo_rd_en}, 32'd0);
        if (ip_inc) ip_count++;
        if (complete) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_complete", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("immediate", {16'd0, immediate}, {16'd0, e.imm});
            chk("bytes_read", {30'd0, bytes_read}, {30'd0, e.nb});
            chk("complete_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int ip0;
    vectors     = 0;
    miscompares = 0;
    ip_count    = 0;
    fifo_cnt    = 0;
    reset       = 1'b1;
    start       = 1'b0;
    is_8bit     = 1'b0;
    sign_extend = 1'b0;
    flush       = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_complete", {31'd0, complete}, 32'd0);
    chk("rst_immediate", {16'd0, immediate}, 32'd0);
    chk("rst_bytes_read", {30'd0, bytes_read}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_ip_inc", {31'd0, ip_inc}, 32'd0);
    reset = 1'b0;
    tick();

    // 16-bit read, FIFO primed: complete at T+4, two ip_inc pulses.
    push_byte(8'h34);
    push_byte(8'h12);
    ip0 = ip_count;
    issue(1'b0, 1'b0, t);
    expect_done(16'h1234, 2'd2, t + 4);
    wait_idle();
    chk("ip_inc_16bit", ip_count - ip0, 2);

    // 8-bit reads of 0xF0, sign- and zero-extended: complete at T+3.
    push_byte(8'hF0);
    ip0 = ip_count;
    issue(1'b1, 1'b1, t);
    expect_done(16'hFFF0, 2'd1, t + 3);
    wait_idle();
    chk("ip_inc_8bit", ip_count - ip0, 1);
    push_byte(8'hF0);
    issue(1'b1, 1'b0, t);
    expect_done(16'h00F0, 2'd1, t + 3);
    wait_idle();

    // 16-bit read, FIFO empty for cycles T+2..T+4: complete at T+7.
    push_byte(8'h78);
    ip0 = ip_count;
    issue(1'b0, 1'b1, t);
    expect_done(16'h5678, 2'd2, t + 7);
    repeat (4) tick();
    push_byte(8'h56);
    wait_idle();
    chk("ip_inc_stall", ip_count - ip0, 2);

    // Flush during CAPTURE_LO: no complete, immediate held, idle next cycle.
    push_byte(8'hAA);
    push_byte(8'hBB);
    ip0 = ip_count;
    issue(1'b0, 1'b0, t);
    tick();
    flush = 1'b1;
    #2;
    chk("rd_en_in_flush", {31'd0, fifo_rd_en}, 32'd0);
    tick();
    flush = 1'b0;
    fifo_q.delete();
    fifo_cnt = 0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_immediate", {16'd0, immediate}, 32'h5678);
    chk("ip_inc_flush", ip_count - ip0, 1);
    push_byte(8'h11);
    issue(1'b1, 1'b0, t);
    expect_done(16'h0011, 2'd1, t + 3);
    wait_idle();

    // start together with flush is dropped.
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("start_flush_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("start_flush_busy2", {31'd0, busy}, 32'd0);

    // start held high while busy (including DONE) gives one complete only.
    push_byte(8'h22);
    push_byte(8'h33);
    ip0 = ip_count;
    issue(1'b0, 1'b0, t);
    expect_done(16'h3322, 2'd2, t + 4);
    tick();
    start   = 1'b1;
    is_8bit = 1'b1;
    tick();
    tick();
    tick();
    start   = 1'b0;
    is_8bit = 1'b0;
    tick();
    chk("busy_start_ignored", {31'd0, busy}, 32'd0);
    chk("ip_inc_busy_start", ip_count - ip0, 2);

    // Reset in FETCH_HI: all outputs at reset values next cycle.
    push_byte(8'h44);
    issue(1'b0, 1'b0, t);
    tick();
    tick();
    chk("in_fetch_hi_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_complete", {31'd0, complete}, 32'd0);
    chk("mid_rst_immediate", {16'd0, immediate}, 32'd0);
    chk("mid_rst_bytes_read", {30'd0, bytes_read}, 32'd0);
    chk("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("mid_rst_ip_inc", {31'd0, ip_inc}, 32'd0);
    reset = 1'b0;
    repeat (5) tick();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
